// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the 8-bit core. It fetches 16-bit instructions
// over a req/ack handshake, decodes them, and drives the datapath strobes and
// the control for the immediate-extension unit. It performs no arithmetic.
module multicycle_ctrl #(
  parameter int WAIT_LIMIT = 15  // max consecutive ack-wait cycles, 1..255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [15:0] instr,
  input  logic       mem_ack,
  input  logic       zero,
  output logic       mem_req,
  output logic       mem_we,
  output logic       addr_sel,
  output logic       IR_load,
  output logic       PC_write,
  output logic       PC_src,
  output logic       CS,
  output logic [5:0] immediate,
  output logic       ALU_B_sel,
  output logic [1:0] ALU_op,
  output logic       RegWrite,
  output logic       WB_sel,
  output logic [2:0] rd_addr,
  output logic [2:0] rs_addr,
  output logic       halted,
  output logic       illegal,
  output logic       bus_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_AND  = 4'h3,
    OP_OR   = 4'h4,
    OP_ADDI = 4'h5,
    OP_ANDI = 4'h6,
    OP_ORI  = 4'h7,
    OP_LW   = 4'h8,
    OP_SW   = 4'h9,
    OP_BEQ  = 4'hA,
    OP_HLT  = 4'hF
  } opcode_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  // Last wait-count value before the handshake is declared dead.
  localparam logic [7:0] WAIT_LAST = 8'(WAIT_LIMIT - 1);

  state_t      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic [7:0]  wait_q, wait_d;
  logic        illegal_q, illegal_d;
  logic        bus_err_q, bus_err_d;

  opcode_t     op;
  logic        is_lw, is_sw;
  logic        dec_b_sel;
  logic [1:0]  dec_alu_op;

  assign op        = opcode_t'(ir_q[15:12]);
  assign is_lw     = (op == OP_LW);
  assign is_sw     = (op == OP_SW);
  assign immediate = ir_q[5:0];
  assign rs_addr   = ir_q[8:6];
  assign rd_addr   = ir_q[11:9];
  assign illegal   = illegal_q;
  assign bus_err   = bus_err_q;

  // Opcode decode: ALU function, B-operand source and extension mode.
  // NOTE: every signal written here gets a default first so no path leaves it
  // unassigned -- otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    dec_alu_op = ALU_ADD;
    dec_b_sel  = 1'b0;
    CS         = 1'b0;
    case (op)
      OP_SUB:  dec_alu_op = ALU_SUB;
      OP_AND:  dec_alu_op = ALU_AND;
      OP_OR:   dec_alu_op = ALU_OR;
      OP_ADDI: begin dec_b_sel = 1'b1; CS = 1'b1; end
      OP_ANDI: begin dec_b_sel = 1'b1; dec_alu_op = ALU_AND; end
      OP_ORI:  begin dec_b_sel = 1'b1; dec_alu_op = ALU_OR; end
      OP_LW,
      OP_SW:   begin dec_b_sel = 1'b1; CS = 1'b1; end
      OP_BEQ:  begin dec_alu_op = ALU_SUB; CS = 1'b1; end
      default: ;
    endcase
  end

  // Next-state, strobe and handshake-timeout logic.
  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    wait_d    = '0;  // any state change clears the count for the next access
    illegal_d = illegal_q;
    bus_err_d = bus_err_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    addr_sel  = 1'b0;
    IR_load   = 1'b0;
    PC_write  = 1'b0;
    PC_src    = 1'b0;
    ALU_B_sel = 1'b0;
    ALU_op    = ALU_ADD;
    RegWrite  = 1'b0;
    WB_sel    = 1'b0;
    halted    = 1'b0;

    case (state_q)
      S_IDLE: state_d = S_FETCH;

      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_d     = instr;
          IR_load  = 1'b1;
          PC_write = 1'b1;
          state_d  = S_DECODE;
        end else if (wait_q == WAIT_LAST) begin
          bus_err_d = 1'b1;
          state_d   = S_HALT;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end

      S_DECODE: state_d = S_EXEC;

      S_EXEC: begin
        ALU_op    = dec_alu_op;
        ALU_B_sel = dec_b_sel;
        case (op)
          OP_ADD, OP_SUB, OP_AND, OP_OR,
          OP_ADDI, OP_ANDI, OP_ORI: state_d = S_WB;
          OP_LW, OP_SW:             state_d = S_MEM;
          OP_BEQ: begin
            PC_write = zero;
            PC_src   = zero;
            state_d  = S_FETCH;
          end
          OP_NOP:                   state_d = S_FETCH;
          OP_HLT:                   state_d = S_HALT;
          default: begin
            illegal_d = 1'b1;
            state_d   = S_HALT;
          end
        endcase
      end

      S_MEM: begin
        mem_req   = 1'b1;
        addr_sel  = 1'b1;
        mem_we    = is_sw;
        ALU_op    = dec_alu_op;
        ALU_B_sel = dec_b_sel;
        if (mem_ack) begin
          state_d = is_sw ? S_FETCH : S_WB;
        end else if (wait_q == WAIT_LAST) begin
          bus_err_d = 1'b1;
          state_d   = S_HALT;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end

      S_WB: begin
        RegWrite  = 1'b1;
        WB_sel    = is_lw;
        ALU_op    = dec_alu_op;
        ALU_B_sel = dec_b_sel;
        state_d   = S_FETCH;
      end

      S_HALT: halted = 1'b1;

      default: state_d = S_IDLE;
    endcase
  end

  // State, IR, wait counter and sticky flags; synchronous active-low reset.
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      ir_q      <= '0;
      wait_q    <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      wait_q    <= wait_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: the stimulus process drives one cycle at a time
// and queues the hand-derived output vector expected in that cycle; a monitor
// pops and compares on the falling edge.
module tb_multicycle_ctrl;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       addr_sel;
    logic       ir_load;
    logic       pc_write;
    logic       pc_src;
    logic       cs;
    logic [5:0] imm;
    logic       b_sel;
    logic [1:0] alu_op;
    logic       reg_write;
    logic       wb_sel;
    logic [2:0] rd;
    logic [2:0] rs;
    logic       halted;
    logic       illegal;
    logic       bus_err;
  } out_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] instr;
  logic        mem_ack, zero;
  logic        mem_req, mem_we, addr_sel, IR_load, PC_write, PC_src, CS;
  logic [5:0]  immediate;
  logic        ALU_B_sel;
  logic [1:0]  ALU_op;
  logic        RegWrite, WB_sel;
  logic [2:0]  rd_addr, rs_addr;
  logic        halted, illegal, bus_err;

  out_t  act;
  out_t  exp_q[$];
  string nm_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  multicycle_ctrl #(.WAIT_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .mem_ack(mem_ack), .zero(zero),
    .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel),
    .IR_load(IR_load), .PC_write(PC_write), .PC_src(PC_src), .CS(CS),
    .immediate(immediate), .ALU_B_sel(ALU_B_sel), .ALU_op(ALU_op),
    .RegWrite(RegWrite), .WB_sel(WB_sel), .rd_addr(rd_addr),
    .rs_addr(rs_addr), .halted(halted), .illegal(illegal), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  assign act = {mem_req, mem_we, addr_sel, IR_load, PC_write, PC_src, CS,
                immediate, ALU_B_sel, ALU_op, RegWrite, WB_sel, rd_addr,
                rs_addr, halted, illegal, bus_err};

  // Monitor: compare the DUT outputs with the oldest queued expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      out_t  e;
      string nm;
      e  = exp_q.pop_front();
      nm = nm_q.pop_front();
      n_cmp++;
      if (act !== e) begin
        n_bad++;
        $display("FAIL %s: got %07h expected %07h", nm, act, e);
      end
    end
  end

  // Watchdog so the run can never hang.
  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic out_t base(input logic [15:0] ir, input logic cs);
    out_t v = '0;
    v.cs  = cs;
    v.imm = ir[5:0];
    v.rd  = ir[11:9];
    v.rs  = ir[8:6];
    return v;
  endfunction

  function automatic out_t fe(input logic [15:0] ir, input logic cs,
                              input logic ack);
    out_t v = base(ir, cs);
    v.mem_req  = 1'b1;
    v.ir_load  = ack;
    v.pc_write = ack;
    return v;
  endfunction

  function automatic out_t ex(input logic [15:0] ir, input logic cs,
                              input logic bsel, input logic [1:0] op);
    out_t v = base(ir, cs);
    v.b_sel  = bsel;
    v.alu_op = op;
    return v;
  endfunction

  // Drive one cycle of inputs and queue the outputs expected in that cycle.
  task automatic step(input string nm, input logic ack, input logic z,
                      input logic [15:0] ins, input out_t e);
    mem_ack = ack;
    zero    = z;
    instr   = ins;
    exp_q.push_back(e);
    nm_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  // Register/immediate ALU instruction with zero-wait fetch: FETCH..WB.
  task automatic run_alu(input string nm, input logic [15:0] ins,
                         input logic [15:0] prev_ir, input logic prev_cs,
                         input logic cs, input logic bsel,
                         input logic [1:0] op);
    out_t e;
    step({nm, "_fetch"}, 1'b1, 1'b0, ins, fe(prev_ir, prev_cs, 1'b1));
    step({nm, "_decode"}, 1'b0, 1'b0, 16'h0, base(ins, cs));
    step({nm, "_exec"}, 1'b0, 1'b0, 16'h0, ex(ins, cs, bsel, op));
    e = ex(ins, cs, bsel, op);
    e.reg_write = 1'b1;
    step({nm, "_wb"}, 1'b0, 1'b0, 16'h0, e);
  endtask

  task automatic hold_reset();
    rst_n   = 1'b0;
    mem_ack = 1'b0;
    zero    = 1'b0;
    instr   = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    out_t e;

    // Reset, idle, and reset abandoning a pending fetch.
    hold_reset();
    step("idle", 1'b0, 1'b0, 16'h0, '0);
    step("fetch_req", 1'b0, 1'b0, 16'h0, fe(16'h0, 1'b0, 1'b0));
    rst_n = 1'b0;
    step("fetch_at_rst", 1'b0, 1'b0, 16'h0, fe(16'h0, 1'b0, 1'b0));
    step("after_rst", 1'b0, 1'b0, 16'h0, '0);
    rst_n = 1'b1;
    step("idle2", 1'b0, 1'b0, 16'h0, '0);

    // ADDI r1,r2,-3; ORI imm=0x20; SUB r0,r1.
    run_alu("addi", 16'h52BD, 16'h0000, 1'b0, 1'b1, 1'b1, 2'b00);
    run_alu("ori",  16'h7020, 16'h52BD, 1'b1, 1'b0, 1'b1, 2'b11);
    run_alu("sub",  16'h2050, 16'h7020, 1'b0, 1'b0, 1'b0, 2'b01);

    // LW r5,5(r2) with a 3-cycle ack delay in MEM.
    step("lw_fetch", 1'b1, 1'b0, 16'h8A85, fe(16'h2050, 1'b0, 1'b1));
    step("lw_decode", 1'b0, 1'b0, 16'h0, base(16'h8A85, 1'b1));
    step("lw_exec", 1'b0, 1'b0, 16'h0, ex(16'h8A85, 1'b1, 1'b1, 2'b00));
    e = ex(16'h8A85, 1'b1, 1'b1, 2'b00);
    e.mem_req  = 1'b1;
    e.addr_sel = 1'b1;
    for (int i = 0; i < 3; i++) step("lw_mem_wait", 1'b0, 1'b0, 16'h0, e);
    step("lw_mem_ack", 1'b1, 1'b0, 16'h0, e);
    e = ex(16'h8A85, 1'b1, 1'b1, 2'b00);
    e.reg_write = 1'b1;
    e.wb_sel    = 1'b1;
    step("lw_wb", 1'b0, 1'b0, 16'h0, e);

    // SW r3,-1(r4): mem_we in MEM, then straight back to FETCH.
    step("sw_fetch", 1'b1, 1'b0, 16'h973F, fe(16'h8A85, 1'b1, 1'b1));
    step("sw_decode", 1'b0, 1'b0, 16'h0, base(16'h973F, 1'b1));
    step("sw_exec", 1'b0, 1'b0, 16'h0, ex(16'h973F, 1'b1, 1'b1, 2'b00));
    e = ex(16'h973F, 1'b1, 1'b1, 2'b00);
    e.mem_req  = 1'b1;
    e.addr_sel = 1'b1;
    e.mem_we   = 1'b1;
    step("sw_mem", 1'b1, 1'b0, 16'h0, e);

    // BEQ taken, then BEQ not taken.
    step("beq1_fetch", 1'b1, 1'b0, 16'hA03E, fe(16'h973F, 1'b1, 1'b1));
    step("beq1_decode", 1'b0, 1'b0, 16'h0, base(16'hA03E, 1'b1));
    e = ex(16'hA03E, 1'b1, 1'b0, 2'b01);
    e.pc_write = 1'b1;
    e.pc_src   = 1'b1;
    step("beq1_exec_taken", 1'b0, 1'b1, 16'h0, e);
    step("beq2_fetch", 1'b1, 1'b0, 16'hA03E, fe(16'hA03E, 1'b1, 1'b1));
    step("beq2_decode", 1'b0, 1'b0, 16'h0, base(16'hA03E, 1'b1));
    step("beq2_exec_not", 1'b0, 1'b0, 16'h0, ex(16'hA03E, 1'b1, 1'b0, 2'b01));

    // Fetch acked on the last allowed wait cycle: normal decode of a NOP.
    for (int i = 0; i < 3; i++)
      step("fetch_wait", 1'b0, 1'b0, 16'h0, fe(16'hA03E, 1'b1, 1'b0));
    step("fetch_ack_last", 1'b1, 1'b0, 16'h0123, fe(16'hA03E, 1'b1, 1'b1));
    step("nop_decode", 1'b0, 1'b0, 16'h0, base(16'h0123, 1'b0));
    step("nop_exec", 1'b0, 1'b0, 16'h0, base(16'h0123, 1'b0));

    // No ack for 4 fetch cycles: bus error and halt; ack in HALT ignored.
    for (int i = 0; i < 4; i++)
      step("fetch_timeout", 1'b0, 1'b0, 16'h0, fe(16'h0123, 1'b0, 1'b0));
    e = base(16'h0123, 1'b0);
    e.halted  = 1'b1;
    e.bus_err = 1'b1;
    step("bus_err_halt", 1'b0, 1'b0, 16'h0, e);
    step("bus_err_hold", 1'b1, 1'b0, 16'h0, e);

    // Illegal opcode 0xC: illegal and halted, no further memory request.
    hold_reset();
    step("ill_idle", 1'b0, 1'b0, 16'h0, '0);
    step("ill_fetch", 1'b1, 1'b0, 16'hC000, fe(16'h0000, 1'b0, 1'b1));
    step("ill_decode", 1'b0, 1'b0, 16'h0, base(16'hC000, 1'b0));
    step("ill_exec", 1'b0, 1'b0, 16'h0, base(16'hC000, 1'b0));
    e = base(16'hC000, 1'b0);
    e.halted  = 1'b1;
    e.illegal = 1'b1;
    step("ill_halt", 1'b0, 1'b0, 16'h0, e);
    step("ill_hold", 1'b1, 1'b0, 16'h0, e);

    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
